// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives one bus cycle per load/store, formats lanes big-endian.
// Latency: 1 cycle for non-memory ops, 2 cycles minimum for loads/stores (+1 per bus wait cycle).
// Backpressure: stall_o holds upstream while a bus cycle is outstanding or downstream stall_i is high.
//
// Ports: clk_i/rst_i (sync, active-high); execute-stage inputs (ir_i, reg_write_i,
// alu_data_i, store_data_i, mem_read_i, mem_write_i, mem_size_i, halt_i, bank_i, stall_i);
// write-back outputs (ir_o, reg_write_o, sp_data_o, halt_o, bank_o, align_fault_o, stall_o);
// bus master (bus_cyc_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o, bus_dat_i, bus_ack_i).
// Optional macro BEXKAT1_MEM_ALIGN_EN: misaligned half/word accesses fault instead of running.
module mem_access (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic [63:0] ir_i,
  input  logic [1:0]  reg_write_i,
  input  logic [31:0] alu_data_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_size_i,
  input  logic        halt_i,
  input  logic [3:0]  bank_i,
  output logic        stall_o,
  output logic [63:0] ir_o,
  output logic [1:0]  reg_write_o,
  output logic [31:0] sp_data_o,
  output logic        halt_o,
  output logic [3:0]  bank_o,
  output logic        align_fault_o,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, HOLD = 2'd2} state_t;
  state_t state_q, state_d;

  logic        mem_op, misalign, start_bus, ld_latched;
  logic [31:0] adr_q, sdat_q, hold_q, rd_fmt, wr_fmt, result;
  logic [1:0]  size_q;
  logic        we_q;
  logic [63:0] ir_q;
  logic [1:0]  rw_q;
  logic        halt_q;
  logic [3:0]  bank_q;

  // Lane 3 (bits 31:24) carries the lowest byte address.
  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   lane_sel = a[1] ? 4'b0011 : 4'b1100;
      2'b10:   lane_sel = 4'b1000 >> a;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  assign mem_op    = mem_read_i | mem_write_i;
  assign start_bus = (state_q == IDLE) && !stall_i && mem_op && !misalign;

`ifdef BEXKAT1_MEM_ALIGN_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      case (mem_size_i)
        2'b01:   misalign = alu_data_i[0];
        2'b10:   misalign = 1'b0;
        default: misalign = |alu_data_i[1:0];
      endcase
    end
  end

  // Fault flag moves with the other pipeline outputs; it only changes on an IDLE advance.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      align_fault_o <= 1'b0;
    else if (state_q == IDLE && !stall_i)
      align_fault_o <= misalign;
  end
`else
  assign misalign      = 1'b0;
  assign align_fault_o = 1'b0;
`endif

  // Load data: pick the addressed lanes and zero-extend.
  always_comb begin
    rd_fmt = bus_dat_i;
    case (size_q)
      2'b01: rd_fmt = adr_q[1] ? {16'h0, bus_dat_i[15:0]} : {16'h0, bus_dat_i[31:16]};
      2'b10: begin
        case (adr_q[1:0])
          2'd0:    rd_fmt = {24'h0, bus_dat_i[31:24]};
          2'd1:    rd_fmt = {24'h0, bus_dat_i[23:16]};
          2'd2:    rd_fmt = {24'h0, bus_dat_i[15:8]};
          default: rd_fmt = {24'h0, bus_dat_i[7:0]};
        endcase
      end
      default: rd_fmt = bus_dat_i;
    endcase
  end

  // Store data replicated across every lane so whichever lanes are selected see it.
  always_comb begin
    case (size_q)
      2'b01:   wr_fmt = {2{sdat_q[15:0]}};
      2'b10:   wr_fmt = {4{sdat_q[7:0]}};
      default: wr_fmt = sdat_q;
    endcase
  end

  assign result    = we_q ? adr_q : rd_fmt;
  assign bus_adr_o = adr_q;
  assign bus_sel_o = lane_sel(size_q, adr_q[1:0]);
  assign bus_dat_o = wr_fmt;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_bus) state_d = BUS;
      BUS:     if (bus_ack_i) state_d = stall_i ? HOLD : IDLE;
      HOLD:    if (!stall_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall_o   = 1'b0;
    bus_cyc_o = 1'b0;
    bus_we_o  = 1'b0;
    case (state_q)
      IDLE: stall_o = stall_i | start_bus;
      BUS: begin
        stall_o   = !bus_ack_i | stall_i;
        bus_cyc_o = 1'b1;
        bus_we_o  = we_q;
      end
      HOLD:    stall_o = stall_i;
      default: stall_o = 1'b0;
    endcase
  end

  // Completed memory op retires either straight from the bus or from the hold register.
  assign ld_latched = ((state_q == BUS) && bus_ack_i && !stall_i) ||
                      ((state_q == HOLD) && !stall_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_o <= '0; reg_write_o <= '0; sp_data_o <= '0; halt_o <= 1'b0; bank_o <= '0;
      adr_q <= '0; sdat_q <= '0; size_q <= '0; we_q <= 1'b0; hold_q <= '0;
      ir_q <= '0; rw_q <= '0; halt_q <= 1'b0; bank_q <= '0;
    end else begin
      if (start_bus) begin
        adr_q  <= alu_data_i;
        sdat_q <= store_data_i;
        size_q <= mem_size_i;
        we_q   <= mem_write_i;
        ir_q   <= ir_i;
        rw_q   <= reg_write_i;
        halt_q <= halt_i;
        bank_q <= bank_i;
        // Bubble: nothing retires while the bus cycle runs.
        reg_write_o <= 2'b00;
        halt_o      <= 1'b0;
      end else if (state_q == IDLE && !stall_i) begin
        ir_o        <= ir_i;
        reg_write_o <= misalign ? 2'b00 : reg_write_i;
        sp_data_o   <= alu_data_i;
        halt_o      <= halt_i;
        bank_o      <= bank_i;
      end
      if (state_q == BUS && bus_ack_i && stall_i)
        hold_q <= result;
      if (ld_latched) begin
        ir_o        <= ir_q;
        reg_write_o <= rw_q;
        sp_data_o   <= (state_q == HOLD) ? hold_q : result;
        halt_o      <= halt_q;
        bank_o      <= bank_q;
      end
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have these ports, clock and reset first: clk_i  in  1  single clock, all state on rising edge; rst_i  in  1  reset, synchronous, active-high.
REQ-002 Pipeline inputs from the execute stage SHALL be: stall_i  in  1  downstream hold; ir_i  in  64  instruction; reg_write_i  in  2  write-back enable; alu_data_i  in  32  ALU result / effective address; store_data_i  in  32  store operand; mem_read_i  in  1  load; mem_write_i  in  1  store; mem_size_i  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word); halt_i  in  1; bank_i  in  4.
REQ-003 Pipeline outputs to the write-back register SHALL be: stall_o  out  1  upstream hold; ir_o  out  64; reg_write_o  out  2; sp_data_o  out  32  result (load data or ALU data); halt_o  out  1; bank_o  out  4; align_fault_o  out  1.
REQ-004 Bus master ports SHALL be: bus_cyc_o  out  1; bus_we_o  out  1; bus_adr_o  out  32; bus_sel_o  out  4; bus_dat_o  out  32; bus_dat_i  in  32; bus_ack_i  in  1.

Function
REQ-005 The FSM SHALL have three states: IDLE, BUS (cycle outstanding), HOLD (load data captured, downstream stalled).
REQ-006 In IDLE with stall_i=0 and no memory op: outputs SHALL register ir_i, reg_write_i, alu_data_i->sp_data_o, halt_i, bank_i on the next edge (1-cycle latency).
REQ-007 In IDLE with stall_i=0 and mem_read_i|mem_write_i: the block SHALL assert stall_o combinationally, latch address, size, store data and pipeline fields, and go to BUS; output fields SHALL take a bubble (reg_write_o=0, halt_o=0).
REQ-008 In BUS: bus_cyc_o=1, bus_we_o=latched write flag, address/sel/data from the latched operands; all three SHALL be stable until bus_ack_i is sampled high.
REQ-009 In BUS, stall_o SHALL be 1 while bus_ack_i=0, and bus_cyc_o SHALL drop on the edge where bus_ack_i=1.
REQ-010 On ack with stall_i=0: next edge SHALL load outputs from the latched fields, sp_data_o = formatted load data (loads) or latched alu data (stores), stall_o=0 in the ack cycle, state->IDLE. Minimum load/store latency is 2 cycles.
REQ-011 On ack with stall_i=1: formatted data SHALL be stored internally, state->HOLD, stall_o=1; in HOLD, when stall_i falls, outputs SHALL be loaded from the hold register and state->IDLE.
REQ-012 Whenever stall_i=1 in IDLE or HOLD, all pipeline outputs SHALL hold their values.
REQ-013 Byte lanes are big-endian: bus_sel_o = 1111 for word; 1100 / 0011 for half at adr[1]=0/1; 1000,0100,0010,0001 for byte at adr[1:0]=0..3.
REQ-014 Store data SHALL be replicated to all selected lanes (byte x4, half x2).
REQ-015 Load data SHALL be extracted from the selected lanes and zero-extended to 32 bits.
REQ-016 bus_adr_o SHALL be alu_data_i unmodified (byte address).
REQ-017 mem_read_i and mem_write_i both high SHALL be treated as a store.

Reset
REQ-018 On rst_i high at a rising edge: state=IDLE, all outputs 0 (ir_o=64'h0, sp_data_o=0, reg_write_o=0, halt_o=0, bank_o=0, align_fault_o=0), bus_cyc_o=0 from the following cycle.
REQ-019 Reset during BUS or HOLD SHALL abandon the transaction; a late bus_ack_i after reset SHALL be ignored.

Configuration
REQ-020 Macro BEXKAT1_MEM_ALIGN_EN defined: half with adr[0]=1 or word with adr[1:0]!=0 SHALL start no bus cycle, drive align_fault_o=1 for one output cycle with reg_write_o=0, pass ir_i through, and not stall.
REQ-021 Macro undefined: align_fault_o tied 0; misaligned accesses SHALL proceed with sel chosen from adr[1] (half) and adr[1:0] ignored (word).

Verification
REQ-022 Non-memory op, ir_i=64'hA, alu_data_i=32'h1234 -> one cycle later sp_data_o=32'h1234, ir_o=64'hA, stall_o never 1.
REQ-023 Word load from 32'h100, ack after 3 wait cycles with bus_dat_i=32'hDEADBEEF -> stall_o high 4 cycles, bus_sel_o=1111, sp_data_o=32'hDEADBEEF.
REQ-024 Byte store of store_data_i=32'h55 to 32'h103 -> bus_we_o=1, bus_sel_o=0001, bus_dat_o=32'h55555555; byte load at 32'h101 with bus_dat_i=32'h11223344 -> sp_data_o=32'h22.
REQ-025 Load acked while stall_i=1 for 2 cycles -> state HOLD, outputs unchanged, data 32'hCAFEF00D appears on sp_data_o the edge after stall_i falls.
REQ-026 rst_i asserted in BUS before ack -> next cycle bus_cyc_o=0, all outputs 0, later ack ignored.
REQ-027 With BEXKAT1_MEM_ALIGN_EN, word load at 32'h102 -> align_fault_o=1, bus_cyc_o stays 0, reg_write_o=0.
